// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit feeder.
package uart_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_GUARD = 400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STROBE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GUARD,
    ST_CKSUM
  } feeder_state_e;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous FIFO with registered read data; a pop makes the head entry
// available on pop_dat in the following cycle.
module sync_byte_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_n_i,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_dat,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_dat,
  output logic                          full,
  output logic                          empty,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge sys_clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      pop_dat <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        pop_dat <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bytes for the UART transmitter, paces write strobes against its
// busy flag and optionally appends an XOR checksum after each packet.
//
// state     | meaning
// IDLE      | wait for a queued byte and an idle transmitter, then pop
// LOAD      | present popped byte, fold it into the checksum
// STROBE    | one-cycle write strobe to the transmitter
// WAIT_ACK  | wait for transmitter busy to rise (bounded)
// WAIT_DONE | wait for transmitter busy to fall
// GUARD     | idle gap before the next byte
// CKSUM     | present the packet checksum as the next byte
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int GUARD_CYCLES = DEFAULT_GUARD,
  parameter int ACK_TIMEOUT  = 4,
  parameter bit CKSUM_EN     = 1'b1
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_n_i,
  input  logic                          wr_en_i,
  input  logic [7:0]                    wr_dat_i,
  input  logic                          pkt_end_i,
  input  logic                          clr_ovf_i,
  output logic                          full_o,
  output logic [level_width(DEPTH)-1:0] level_o,
  output logic                          overflow_o,
  output logic                          busy_o,
  output logic                          uart_wr_o,
  output logic [7:0]                    uart_dat_o,
  input  logic                          uart_busy_i
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int AW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);
  // The strobe cycle counts as the first elapsed clock of the ack window.
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 2);

  feeder_state_e state;
  feeder_state_e state_nxt;
  logic [8:0]    fifo_rd;
  logic          fifo_pop;
  logic          fifo_empty;
  logic [GW-1:0] guard_cnt;
  logic [AW-1:0] ack_cnt;
  logic [7:0]    cks;
  logic          end_flag;
  logic          cks_cur;

  sync_byte_fifo #(
    .WIDTH(9),
    .DEPTH(DEPTH)
  ) u_fifo (
    .sys_clk_i  (sys_clk_i),
    .sys_rst_n_i(sys_rst_n_i),
    .push       (wr_en_i),
    .push_dat   ({pkt_end_i, wr_dat_i}),
    .pop        (fifo_pop),
    .pop_dat    (fifo_rd),
    .full       (full_o),
    .empty      (fifo_empty),
    .level      (level_o)
  );

  assign uart_wr_o = (state == ST_STROBE);
  assign busy_o    = !fifo_empty || (state != ST_IDLE);

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !uart_busy_i) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD:   state_nxt = ST_STROBE;
      ST_STROBE: state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (uart_busy_i)             state_nxt = ST_WAIT_DONE;
        else if (ack_cnt == ACK_LAST) state_nxt = ST_GUARD;
      end
      ST_WAIT_DONE: begin
        if (!uart_busy_i) state_nxt = ST_GUARD;
      end
      ST_GUARD: begin
        if (guard_cnt == '0) state_nxt = (end_flag && !cks_cur) ? ST_CKSUM : ST_IDLE;
      end
      ST_CKSUM: state_nxt = ST_STROBE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      guard_cnt <= '0;
      ack_cnt   <= '0;
    end else begin
      if (state != ST_GUARD && state_nxt == ST_GUARD) guard_cnt <= GUARD_LOAD;
      else if (state == ST_GUARD && guard_cnt != '0)  guard_cnt <= guard_cnt - GW'(1);
      if (state == ST_STROBE)        ack_cnt <= '0;
      else if (state == ST_WAIT_ACK) ack_cnt <= ack_cnt + AW'(1);
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      uart_dat_o <= '0;
      cks        <= '0;
      end_flag   <= 1'b0;
      cks_cur    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          uart_dat_o <= fifo_rd[7:0];
          cks        <= cks ^ fifo_rd[7:0];
          end_flag   <= CKSUM_EN & fifo_rd[8];
        end
        ST_CKSUM: begin
          uart_dat_o <= cks;
          cks        <= '0;
          end_flag   <= 1'b0;
          cks_cur    <= 1'b1;
        end
        ST_GUARD: begin
          if (state_nxt == ST_IDLE) cks_cur <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A push attempted while full wins over a same-cycle clear.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i)           overflow_o <= 1'b0;
    else if (wr_en_i && full_o) overflow_o <= 1'b1;
    else if (clr_ovf_i)         overflow_o <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomised scoreboard bench for uart_tx_feeder with a behavioural
// transmitter model and a packet-level expected byte stream.
module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int GUARD  = 400;
  localparam int ACK_TO = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  typedef enum int {X_NORMAL, X_SILENT, X_STUCK} xmode_e;

  logic          sys_clk_i   = 1'b0;
  logic          sys_rst_n_i = 1'b0;
  logic          wr_en_i     = 1'b0;
  logic [7:0]    wr_dat_i    = 8'h00;
  logic          pkt_end_i   = 1'b0;
  logic          clr_ovf_i   = 1'b0;
  logic          full_o;
  logic [LW-1:0] level_o;
  logic          overflow_o;
  logic          busy_o;
  logic          uart_wr_o;
  logic [7:0]    uart_dat_o;
  logic          uart_busy_i = 1'b0;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pkt_q[$];
  int         strobe_cyc[$];
  xmode_e     xmode     = X_NORMAL;
  int         frame_len = 40;
  int         busy_left = 0;
  bit         rise_pend = 1'b0;
  bit         have_fall = 1'b0;
  int         fall_cyc  = 0;
  bit         prev_wr   = 1'b0;

  uart_tx_feeder #(
    .DEPTH(DEPTH),
    .GUARD_CYCLES(GUARD),
    .ACK_TIMEOUT(ACK_TO),
    .CKSUM_EN(1'b1)
  ) dut (
    .sys_clk_i  (sys_clk_i),
    .sys_rst_n_i(sys_rst_n_i),
    .wr_en_i    (wr_en_i),
    .wr_dat_i   (wr_dat_i),
    .pkt_end_i  (pkt_end_i),
    .clr_ovf_i  (clr_ovf_i),
    .full_o     (full_o),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .busy_o     (busy_o),
    .uart_wr_o  (uart_wr_o),
    .uart_dat_o (uart_dat_o),
    .uart_busy_i(uart_busy_i)
  );

  always #5 sys_clk_i = ~sys_clk_i;
  always @(posedge sys_clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Expected stream: every accepted byte, plus the XOR of the packet after its end byte.
  function automatic void model_push(input logic [7:0] d, input logic e);
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(d);
    pkt_q.push_back(d);
    if (e) begin
      foreach (pkt_q[i]) x = x ^ pkt_q[i];
      exp_q.push_back(x);
      pkt_q.delete();
    end
  endfunction

  // Monitor, then transmitter model.
  always @(negedge sys_clk_i) begin
    if (sys_rst_n_i && uart_wr_o) begin
      strobe_cyc.push_back(cyc);
      check("strobe_width", int'(prev_wr), 0);
      check("strobe_vs_busy", int'(uart_busy_i), 0);
      if (have_fall) check("guard_gap", int'((cyc - fall_cyc) > GUARD), 1);
      check("scoreboard_has_entry", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("tx_data", int'(uart_dat_o), int'(exp_q.pop_front()));
    end
    prev_wr = uart_wr_o;

    case (xmode)
      X_STUCK: uart_busy_i = 1'b1;
      X_SILENT: begin
        if (uart_busy_i && sys_rst_n_i) begin
          fall_cyc  = cyc;
          have_fall = 1'b1;
        end
        uart_busy_i = 1'b0;
        rise_pend   = 1'b0;
      end
      default: begin
        if (rise_pend) begin
          uart_busy_i = 1'b1;
          busy_left   = frame_len;
          rise_pend   = 1'b0;
        end else if (uart_busy_i) begin
          busy_left--;
          if (busy_left <= 0) begin
            uart_busy_i = 1'b0;
            if (sys_rst_n_i) begin
              fall_cyc  = cyc;
              have_fall = 1'b1;
            end
          end
        end
        if (sys_rst_n_i && uart_wr_o) rise_pend = 1'b1;
      end
    endcase
  end

  task automatic push(input logic [7:0] d, input logic e, input bit track);
    wr_en_i   = 1'b1;
    wr_dat_i  = d;
    pkt_end_i = e;
    if (track) model_push(d, e);
    @(negedge sys_clk_i);
    wr_en_i   = 1'b0;
    pkt_end_i = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int limit, input string name);
    int k;
    k = 0;
    while (strobe_cyc.size() < n && k < limit) begin
      @(negedge sys_clk_i);
      k++;
    end
    check({name, "_strobe_seen"}, int'(strobe_cyc.size() >= n), 1);
  endtask

  task automatic wait_idle(input int limit, input string name, output int t_idle);
    int k;
    k = 0;
    while ((busy_o || uart_busy_i || rise_pend) && k < limit) begin
      @(negedge sys_clk_i);
      k++;
    end
    t_idle = cyc;
    check({name, "_idle_reached"}, int'(!busy_o && !uart_busy_i), 1);
  endtask

  task automatic enter_reset();
    sys_rst_n_i = 1'b0;
    xmode       = X_SILENT;
    exp_q.delete();
    pkt_q.delete();
  endtask

  task automatic leave_reset();
    repeat (3) @(negedge sys_clk_i);
    sys_rst_n_i = 1'b1;
    @(negedge sys_clk_i);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int t_idle;
    int len;
    int n0;

    repeat (3) @(negedge sys_clk_i);
    check("rst_uart_wr", int'(uart_wr_o), 0);
    check("rst_uart_dat", int'(uart_dat_o), 0);
    check("rst_level", int'(level_o), 0);
    check("rst_full", int'(full_o), 0);
    check("rst_overflow", int'(overflow_o), 0);
    check("rst_busy", int'(busy_o), 0);
    sys_rst_n_i = 1'b1;
    @(negedge sys_clk_i);

    // Single byte: latency and busy_o released only after the guard gap.
    xmode     = X_NORMAL;
    frame_len = 40;
    strobe_cyc.delete();
    push(8'h55, 1'b0, 1'b1);
    e0 = cyc;
    wait_strobes(1, 50, "single");
    if (strobe_cyc.size() >= 1) check("single_latency", strobe_cyc[0] - e0, 2);
    check("single_busy_during_tx", int'(busy_o), 1);
    wait_idle(5000, "single", t_idle);
    if (strobe_cyc.size() >= 1)
      check("single_busy_after_guard", int'((t_idle - strobe_cyc[0]) >= GUARD), 1);
    check("single_strobe_count", strobe_cyc.size(), 1);

    // Packet with checksum, then a one-byte packet proving the checksum restarted.
    push(8'h12, 1'b0, 1'b1);
    push(8'h34, 1'b0, 1'b1);
    push(8'h56, 1'b1, 1'b1);
    push(8'hA5, 1'b1, 1'b1);
    wait_idle(20000, "packet", t_idle);
    check("packet_drained", exp_q.size(), 0);

    // Ack timeout: transmitter never acknowledges.
    xmode = X_SILENT;
    @(negedge sys_clk_i);
    strobe_cyc.delete();
    push(8'h3C, 1'b0, 1'b1);
    push(8'hC3, 1'b0, 1'b1);
    wait_strobes(2, 2000, "timeout");
    if (strobe_cyc.size() >= 2)
      check("timeout_gap", strobe_cyc[1] - strobe_cyc[0], ACK_TO + GUARD + 2);
    wait_idle(2000, "timeout", t_idle);

    // Long busy: next strobe only after busy falls plus the guard gap.
    xmode     = X_NORMAL;
    frame_len = 3000;
    strobe_cyc.delete();
    push(8'h81, 1'b0, 1'b1);
    push(8'h7E, 1'b1, 1'b1);
    wait_strobes(2, 8000, "longbusy");
    if (strobe_cyc.size() >= 2)
      check("longbusy_gap", int'((strobe_cyc[1] - strobe_cyc[0]) >= 3000 + GUARD), 1);
    wait_idle(10000, "longbusy", t_idle);
    check("longbusy_drained", exp_q.size(), 0);

    // Random bursts of random packets.
    for (int b = 0; b < 5; b++) begin
      frame_len = $urandom_range(10, 80);
      len       = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++)
        push(8'($urandom), logic'($urandom_range(0, 3) == 0), 1'b1);
      wait_idle(20000, "random", t_idle);
    end
    check("random_drained", exp_q.size(), 0);

    // Overflow with the transmitter held busy.
    xmode = X_STUCK;
    repeat (2) @(negedge sys_clk_i);
    for (int i = 0; i < DEPTH; i++) begin
      push(8'(i), 1'b0, 1'b0);
      if (i == DEPTH - 2) check("ovf_not_full_early", int'(full_o), 0);
    end
    check("ovf_full", int'(full_o), 1);
    check("ovf_level_full", int'(level_o), DEPTH);
    check("ovf_not_yet", int'(overflow_o), 0);
    push(8'hEE, 1'b0, 1'b0);
    check("ovf_set", int'(overflow_o), 1);
    check("ovf_level_held", int'(level_o), DEPTH);
    clr_ovf_i = 1'b1;
    push(8'hEF, 1'b0, 1'b0);
    clr_ovf_i = 1'b0;
    check("ovf_set_beats_clr", int'(overflow_o), 1);
    clr_ovf_i = 1'b1;
    @(negedge sys_clk_i);
    clr_ovf_i = 1'b0;
    check("ovf_cleared", int'(overflow_o), 0);
    enter_reset();
    leave_reset();
    check("ovf_reset_level", int'(level_o), 0);
    check("ovf_reset_full", int'(full_o), 0);

    // Reset during WAIT_DONE with five bytes still queued.
    xmode     = X_NORMAL;
    frame_len = 3000;
    @(negedge sys_clk_i);
    strobe_cyc.delete();
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i), 1'b0, 1'b1);
    wait_strobes(1, 50, "midrst");
    repeat (10) @(negedge sys_clk_i);
    check("midrst_queued", int'(level_o), 5);
    enter_reset();
    #1;
    check("midrst_wr", int'(uart_wr_o), 0);
    check("midrst_dat", int'(uart_dat_o), 0);
    check("midrst_level", int'(level_o), 0);
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_full", int'(full_o), 0);
    leave_reset();
    n0 = strobe_cyc.size();
    repeat (600) @(negedge sys_clk_i);
    check("midrst_no_strobe", strobe_cyc.size(), n0);
    check("midrst_idle", int'(busy_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
